dmem_block_memory: RTL and testbench
====================================

DMEM_BLOCK_MEMORY -- requirements
Module: dmem_block_memory

Interface
REQ-001 SHALL have parameter IDX_W, default 8: number of BlockAddr bits used as the storage index (depth 2^IDX_W blocks).
REQ-002 SHALL have parameter ADDR_W, default 26: BlockAddr width; bits above IDX_W-1 are ignored, so addresses alias.
REQ-003 SHALL have parameter BLOCK_W, default 256: block data width in bits.
REQ-004 SHALL have parameter READ_LAT, default 10: read latency in cycles; legal range 1..255.
REQ-005 SHALL have parameter WRITE_LAT, default 10: write latency in cycles; legal range 1..255.
REQ-006 SHALL have port clock, input, 1 bit: clock, rising-edge active.
REQ-007 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port memRen, input, 1 bit: block read request, level, held by the requester until memReadReady.
REQ-009 SHALL have port memWen, input, 1 bit: block write request, level, held by the requester until memWriteDone.
REQ-010 SHALL have port BlockAddr, input, ADDR_W bits: block address.
REQ-011 SHALL have port memDin, input, BLOCK_W bits: write block data.
REQ-012 SHALL have port memDout, output, BLOCK_W bits: read block data.
REQ-013 SHALL have port memReadReady, output, 1 bit: one-cycle pulse; memDout is valid in that cycle.
REQ-014 SHALL have port memWriteDone, output, 1 bit: one-cycle pulse; the write is committed.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, RD_WAIT, WR_WAIT, RESP.
REQ-017 SHALL, in IDLE with memWen=1, latch BlockAddr index and memDin, load the counter with WRITE_LAT-1, and go to WR_WAIT.
REQ-018 SHALL, in IDLE with memRen=1 and memWen=0, latch the BlockAddr index, load the counter with READ_LAT-1, and go to RD_WAIT; memWen takes priority when both are high.
REQ-019 SHALL, in RD_WAIT/WR_WAIT, decrement the counter each cycle and, at counter==0, go to RESP.
REQ-020 SHALL, on the RD_WAIT->RESP edge, register storage[latched index] into memDout and set memReadReady=1 for the RESP cycle only.
REQ-021 SHALL, on the WR_WAIT->RESP edge, write the latched data into storage[latched index] and set memWriteDone=1 for the RESP cycle only.
REQ-022 SHALL give a latency of exactly READ_LAT (or WRITE_LAT) cycles from the accepting edge to the edge that raises the pulse.
REQ-023 SHALL go from RESP to IDLE unconditionally and SHALL ignore memRen/memWen in RESP, so a request still held during the pulse cycle is not re-accepted.
REQ-024 SHALL, after accepting a request, ignore changes to memRen, memWen, BlockAddr and memDin until RESP; a withdrawn request still completes.
REQ-025 SHALL hold memDout at the last read value until the next read completion; writes SHALL NOT change memDout.
REQ-026 SHALL return, on a read to an index written earlier, the most recently committed memDin; a read accepted in the IDLE cycle directly after a write's RESP SHALL see that write.
REQ-027 SHALL generate memReadReady and memWriteDone from registers (no combinational path from inputs).

Reset
REQ-028 SHALL, while reset=0, force the state to IDLE, the counter to 0, and memReadReady, memWriteDone, busy and memDout to 0, asynchronously.
REQ-029 SHALL leave storage contents unaffected by reset.
REQ-030 SHALL discard a write pending in WR_WAIT when reset asserts mid-operation (storage not modified), and SHALL issue no pulse for an aborted operation.
REQ-031 SHALL accept a request on the first rising edge after reset deasserts.

Verification
REQ-032 Write then read: memWen=1, BlockAddr=0x05, memDin=0xA5..A5 -> memWriteDone pulse 10 cycles later; then memRen, same address -> memReadReady after 10 cycles, memDout=0xA5..A5.
REQ-033 Held request: memRen held 2 cycles past the memReadReady pulse -> exactly one pulse; busy=0 in the cycle after RESP; the next read is accepted only at the following IDLE edge.
REQ-034 Simultaneous request: memRen=memWen=1 in IDLE -> write serviced, memWriteDone pulses, memReadReady stays 0.
REQ-035 Aliasing: write 0x11.. to BlockAddr 0x0000105, then read BlockAddr 0x0000005 (IDX_W=8) -> memDout=0x11...
REQ-036 Reset mid-write: reset low at WR_WAIT counter=4 -> outputs 0 immediately, no memWriteDone; a later read of that index returns the prior contents.
REQ-037 Back-to-back writeback then fill: write A, then read B in the cycle after memWriteDone -> read accepted at that edge, memReadReady 10 cycles later, with no lost or duplicated pulse.

Source files
------------

// File: rtl/dmem_block_memory.sv
// Block-granular data memory model with fixed, parameterised read and write
// latency. It accepts one request at a time and answers with a one-cycle
// completion pulse.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   memRen        block read request; level, held until memReadReady
//   memWen        block write request; level, held until memWriteDone
//                 (has priority over memRen)
//   BlockAddr     block address; only the low IDX_W bits select a block
//   memDin        write block data
//   memDout       read block data; holds the last read value
//   memReadReady  one-cycle pulse, memDout valid
//   memWriteDone  one-cycle pulse, write committed
//   busy          high whenever the controller is not idle
module dmem_block_memory #(
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned ADDR_W    = 26,
  parameter int unsigned BLOCK_W   = 256,
  parameter int unsigned READ_LAT  = 10,
  parameter int unsigned WRITE_LAT = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               memRen,
  input  logic               memWen,
  input  logic [ADDR_W-1:0]  BlockAddr,
  input  logic [BLOCK_W-1:0] memDin,
  output logic [BLOCK_W-1:0] memDout,
  output logic               memReadReady,
  output logic               memWriteDone,
  output logic               busy
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] dout_q, dout_d;
  logic               rd_pulse_q, rd_pulse_d;
  logic               wr_pulse_q, wr_pulse_d;
  logic               busy_q, busy_d;
  logic               mem_we_c;

  // Storage is deliberately outside the reset domain.
  logic [BLOCK_W-1:0] storage_q [DEPTH];

  // Upper address bits alias and are intentionally dropped.
  logic unused_addr_hi_c;
  assign unused_addr_hi_c = ^BlockAddr[ADDR_W-1:IDX_W];

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    dout_d     = dout_q;
    rd_pulse_d = 1'b0;
    wr_pulse_d = 1'b0;
    mem_we_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memWen) begin
          idx_d   = BlockAddr[IDX_W-1:0];
          data_d  = memDin;
          cnt_d   = CNT_W'(WRITE_LAT - 1);
          state_d = WR_WAIT;
        end else if (memRen) begin
          idx_d   = BlockAddr[IDX_W-1:0];
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          dout_d     = storage_q[idx_q];
          rd_pulse_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          mem_we_c   = 1'b1;
          wr_pulse_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Requests still held here are not re-accepted until IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      dout_q     <= '0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      dout_q     <= dout_d;
      rd_pulse_q <= rd_pulse_d;
      wr_pulse_q <= wr_pulse_d;
      busy_q     <= busy_d;
    end
  end

  // Commit happens on the WR_WAIT->RESP edge; an aborted write never gets here.
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      storage_q[idx_q] <= data_q;
    end
  end

  assign memDout      = dout_q;
  assign memReadReady = rd_pulse_q;
  assign memWriteDone = wr_pulse_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dmem_block_memory.sv
// Scoreboard bench for dmem_block_memory: requests push the expected
// completion (kind, data, cycle) and a negedge monitor checks each pulse.
module tb_dmem_block_memory;

  localparam int unsigned IDX_W   = 8;
  localparam int unsigned ADDR_W  = 26;
  localparam int unsigned BLOCK_W = 256;
  localparam int unsigned LAT     = 10;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               memRen = 1'b0;
  logic               memWen = 1'b0;
  logic [ADDR_W-1:0]  BlockAddr = '0;
  logic [BLOCK_W-1:0] memDin = '0;
  logic [BLOCK_W-1:0] memDout;
  logic               memReadReady;
  logic               memWriteDone;
  logic               busy;

  dmem_block_memory #(
    .IDX_W(IDX_W), .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W),
    .READ_LAT(LAT), .WRITE_LAT(LAT)
  ) dut (
    .clock(clock), .reset(reset), .memRen(memRen), .memWen(memWen),
    .BlockAddr(BlockAddr), .memDin(memDin), .memDout(memDout),
    .memReadReady(memReadReady), .memWriteDone(memWriteDone), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit                 is_rd;
    logic [BLOCK_W-1:0] data;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [BLOCK_W-1:0] D_A5 = {32{8'hA5}};
  localparam logic [BLOCK_W-1:0] D_11 = {32{8'h11}};
  localparam logic [BLOCK_W-1:0] D_5C = {32{8'h5C}};
  localparam logic [BLOCK_W-1:0] D_77 = {32{8'h77}};
  localparam logic [BLOCK_W-1:0] D_EE = {32{8'hEE}};
  localparam logic [BLOCK_W-1:0] D_3C = {32{8'h3C}};

  task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                       input logic [BLOCK_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Completion monitor.
  always @(negedge clock) begin
    if (reset && (memReadReady || memWriteDone)) begin
      n_cmp++;
      if (memReadReady && memWriteDone) begin
        n_fail++;
        $display("FAIL both_pulses at cycle %0d", cyc);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse rd=%0b wr=%0b at cycle %0d",
                 memReadReady, memWriteDone, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd != memReadReady || e.cyc != cyc ||
            (e.is_rd && memDout !== e.data)) begin
          n_fail++;
          $display("FAIL completion: got rd=%0b cyc=%0d dout=%h required rd=%0b cyc=%0d dout=%h",
                   memReadReady, cyc, memDout, e.is_rd, e.cyc, e.data);
        end
      end
    end
  end

  task automatic wait_pulse(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clock);
      if (memReadReady || memWriteDone) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: no pulse within %0d cycles", name, 3 * LAT);
    end
  endtask

  // Drive a request at a negedge in IDLE; it is accepted on the next posedge.
  task automatic issue(input bit ren, input bit wen, input logic [ADDR_W-1:0] addr,
                       input logic [BLOCK_W-1:0] din, input logic [BLOCK_W-1:0] exp_data,
                       input bit withdraw);
    exp_t e;
    @(negedge clock);
    memRen = ren; memWen = wen; BlockAddr = addr; memDin = din;
    e.is_rd = ren && !wen;
    e.data  = exp_data;
    e.cyc   = cyc + 1 + int'(LAT);
    sb.push_back(e);
    @(negedge clock);
    // Scramble inputs after acceptance; they must be ignored.
    BlockAddr = ~addr;
    memDin    = ~din;
    if (withdraw) begin
      memRen = 1'b0; memWen = 1'b0;
    end
    wait_pulse("issue");
    memRen = 1'b0; memWen = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
    issue(1'b0, 1'b1, a, d, '0, 1'b0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
    issue(1'b1, 1'b0, a, '0, d, 1'b0);
  endtask

  initial begin
    int c0;
    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", BLOCK_W'(busy), '0);
    check("rst_rd_pulse", BLOCK_W'(memReadReady), '0);
    check("rst_wr_pulse", BLOCK_W'(memWriteDone), '0);
    check("rst_dout", memDout, '0);
    reset = 1'b1;

    // Write then read, first request right after reset release.
    wr(26'h05, D_A5);
    rd(26'h05, D_A5);
    check("dout_after_read", memDout, D_A5);

    // Aliasing of upper address bits.
    wr(26'h0000105, D_11);
    rd(26'h0000005, D_11);

    // Writes leave memDout alone.
    wr(26'h33, D_5C);
    check("dout_hold_after_write", memDout, D_11);

    // Simultaneous request: write wins.
    issue(1'b1, 1'b1, 26'h40, D_77, '0, 1'b0);
    check("dout_hold_after_simul", memDout, D_11);
    rd(26'h40, D_77);

    // Withdrawn read still completes.
    issue(1'b1, 1'b0, 26'h33, '0, D_5C, 1'b1);

    // Held read: re-accepted only at the IDLE edge after RESP.
    begin
      exp_t e;
      @(negedge clock);
      memRen = 1'b1; BlockAddr = 26'h40;
      e.is_rd = 1'b1; e.data = D_77; e.cyc = cyc + 1 + int'(LAT);
      sb.push_back(e);
      wait_pulse("held");
      @(negedge clock);
      check("held_busy_idle", BLOCK_W'(busy), '0);
      e.cyc = cyc + 1 + int'(LAT);
      sb.push_back(e);
      @(negedge clock);
      check("held_busy_reaccept", BLOCK_W'(busy), 1);
      memRen = 1'b0;
      wait_pulse("held2");
    end

    // Reset during WR_WAIT with counter at 4.
    @(negedge clock);
    memWen = 1'b1; BlockAddr = 26'h33; memDin = D_EE;
    c0 = cyc;
    repeat (6) @(negedge clock);
    check("abort_cycle", BLOCK_W'(cyc), BLOCK_W'(c0 + 6));
    reset = 1'b0;
    #1;
    check("abort_busy", BLOCK_W'(busy), '0);
    check("abort_dout", memDout, '0);
    check("abort_pulses", BLOCK_W'({memReadReady, memWriteDone}), '0);
    memWen = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2 * LAT) @(negedge clock);
    rd(26'h33, D_5C);

    // Writeback then fill, back to back.
    wr(26'h60, D_3C);
    rd(26'h40, D_77);
    rd(26'h60, D_3C);

    repeat (3) @(negedge clock);
    check("sb_drained", BLOCK_W'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
